// File: rtl/f2c_queue_scheduler_pkg.sv
// rtl/f2c_queue_scheduler_pkg.sv - shared types, sizes and ring free-space helper
package f2c_queue_scheduler_pkg;

    localparam int MAX_NB_APPS = 16;
    localparam int RB_AWIDTH   = 16;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SEARCH,
        ST_OFFER,
        ST_BUSY
    } f2c_sched_state_t;

    // One slot is always kept empty so a full ring never looks empty.
    function automatic logic [RB_AWIDTH:0] rb_free(
        input logic [RB_AWIDTH-1:0] head,
        input logic [RB_AWIDTH-1:0] tail,
        input logic [RB_AWIDTH:0]   rb_size
    );
        logic [RB_AWIDTH:0] used;
        used = ({1'b0, tail} - {1'b0, head}) & (rb_size - (RB_AWIDTH+1)'(1));
        if (rb_size == '0) begin
            return '0;
        end
        return rb_size - (RB_AWIDTH+1)'(1) - used;
    endfunction

endpackage

// File: rtl/f2c_queue_scheduler_if.sv
// rtl/f2c_queue_scheduler_if.sv - request/selection/completion handshake between scheduler and DMA engine
// master: scheduler (drives sel_*); slave: fpga2cpu DMA engine (drives req_*, sel_ready, dma_done, new_tail)
interface f2c_queue_scheduler_if
    import f2c_queue_scheduler_pkg::*;
();
    logic                 req_valid;
    logic [RB_AWIDTH-1:0] req_size;
    logic                 sel_valid;
    logic                 sel_ready;
    logic [3:0]           sel_id;
    logic [RB_AWIDTH-1:0] sel_head;
    logic [RB_AWIDTH-1:0] sel_tail;
    logic [63:0]          sel_kmem_addr;
    logic                 dma_done;
    logic [RB_AWIDTH-1:0] new_tail;

    modport master (
        input  req_valid, req_size, sel_ready, dma_done, new_tail,
        output sel_valid, sel_id, sel_head, sel_tail, sel_kmem_addr
    );

    modport slave (
        output req_valid, req_size, sel_ready, dma_done, new_tail,
        input  sel_valid, sel_id, sel_head, sel_tail, sel_kmem_addr
    );
endinterface

// File: rtl/f2c_sched_ctx.sv
// rtl/f2c_sched_ctx.sv - per-queue tail register file with one write port and a combinational context read mux
// Ports: clk/resetn; wr_en/wr_id/wr_tail tail write; rd_id selects head/tail/kmem read-out; tails_flat exposes all tails
module f2c_sched_ctx
    import f2c_queue_scheduler_pkg::*;
#(
    parameter int NB_QUEUES = MAX_NB_APPS
) (
    input  logic                           clk,
    input  logic                           resetn,
    input  logic                           wr_en,
    input  logic [3:0]                     wr_id,
    input  logic [RB_AWIDTH-1:0]           wr_tail,
    input  logic [3:0]                     rd_id,
    input  logic [NB_QUEUES*RB_AWIDTH-1:0] heads_flat,
    input  logic [NB_QUEUES*64-1:0]        kmem_flat,
    output logic [RB_AWIDTH-1:0]           rd_head,
    output logic [RB_AWIDTH-1:0]           rd_tail,
    output logic [63:0]                    rd_kmem,
    output logic [NB_QUEUES*RB_AWIDTH-1:0] tails_flat
);

    logic [RB_AWIDTH-1:0] tails [NB_QUEUES];

    always_ff @(posedge clk) begin
        if (!resetn) begin
            for (int i = 0; i < NB_QUEUES; i++) begin
                tails[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NB_QUEUES; i++) begin
                if (wr_en && (wr_id == 4'(i))) begin
                    tails[i] <= wr_tail;
                end
            end
        end
    end

    always_comb begin
        rd_head = '0;
        rd_tail = '0;
        rd_kmem = '0;
        for (int i = 0; i < NB_QUEUES; i++) begin
            if (rd_id == 4'(i)) begin
                rd_head = heads_flat[i*RB_AWIDTH +: RB_AWIDTH];
                rd_tail = tails[i];
                rd_kmem = kmem_flat[i*64 +: 64];
            end
        end
    end

    always_comb begin
        tails_flat = '0;
        for (int i = 0; i < NB_QUEUES; i++) begin
            tails_flat[i*RB_AWIDTH +: RB_AWIDTH] = tails[i];
        end
    end

endmodule

// File: rtl/f2c_queue_scheduler.sv
// rtl/f2c_queue_scheduler.sv - work-conserving round-robin scheduler selecting the next FPGA-to-CPU ring
// Ports: pcie_clk/pcie_reset_n; total_core, rb_size, heads_flat, kmem_flat configuration and head inputs;
// sched (master) request/selection/completion handshake; tails_flat, err_spurious, stat_* status outputs.
// Build option: F2C_SCHED_STATS_EN enables the grant/skip/stall counters (tied to 0 otherwise).
module f2c_queue_scheduler
    import f2c_queue_scheduler_pkg::*;
#(
    parameter int NB_QUEUES = MAX_NB_APPS
) (
    input  logic                           pcie_clk,
    input  logic                           pcie_reset_n,
    input  logic [4:0]                     total_core,
    input  logic [25:0]                    rb_size,
    input  logic [NB_QUEUES*RB_AWIDTH-1:0] heads_flat,
    input  logic [NB_QUEUES*64-1:0]        kmem_flat,
    f2c_queue_scheduler_if.master          sched,
    output logic [NB_QUEUES*RB_AWIDTH-1:0] tails_flat,
    output logic                           err_spurious,
    output logic [31:0]                    stat_grants,
    output logic [31:0]                    stat_skips,
    output logic [31:0]                    stat_stalls
);

    f2c_sched_state_t     state;
    logic [3:0]           ptr;
    logic [4:0]           scan_cnt;
    logic [4:0]           tc_eff;
    logic [3:0]           cand;
    logic [3:0]           cand_next;
    logic [3:0]           done_next;
    logic [RB_AWIDTH-1:0] rd_head;
    logic [RB_AWIDTH-1:0] rd_tail;
    logic [63:0]          rd_kmem;
    logic [RB_AWIDTH:0]   cand_free;
    logic                 cand_fits;
    logic                 tail_we;
    logic                 unused_rb_size_hi;

    // Rings never exceed 2^RB_AWIDTH entries, so the upper size bits carry no information.
    assign unused_rb_size_hi = |rb_size[25:RB_AWIDTH+1];

    always_comb begin
        tc_eff = total_core;
        if (total_core == 5'd0) begin
            tc_eff = 5'd1;
        end else if (total_core > 5'(NB_QUEUES)) begin
            tc_eff = 5'(NB_QUEUES);
        end
    end

    // A pointer left beyond a shrunken queue count restarts the scan at queue 0.
    assign cand      = ({1'b0, ptr} >= tc_eff) ? 4'd0 : ptr;
    assign cand_next = (({1'b0, cand} + 5'd1) == tc_eff) ? 4'd0 : cand + 4'd1;
    assign done_next = (({1'b0, sched.sel_id} + 5'd1) >= tc_eff) ? 4'd0 : sched.sel_id + 4'd1;

    assign cand_free = rb_free(rd_head, rd_tail, rb_size[RB_AWIDTH:0]);
    assign cand_fits = (sched.req_size != '0) && ({1'b0, sched.req_size} <= cand_free);
    assign tail_we   = sched.dma_done && (state == ST_BUSY);

    f2c_sched_ctx #(
        .NB_QUEUES (NB_QUEUES)
    ) u_ctx (
        .clk        (pcie_clk),
        .resetn     (pcie_reset_n),
        .wr_en      (tail_we),
        .wr_id      (sched.sel_id),
        .wr_tail    (sched.new_tail),
        .rd_id      (cand),
        .heads_flat (heads_flat),
        .kmem_flat  (kmem_flat),
        .rd_head    (rd_head),
        .rd_tail    (rd_tail),
        .rd_kmem    (rd_kmem),
        .tails_flat (tails_flat)
    );

    always_ff @(posedge pcie_clk) begin
        if (!pcie_reset_n) begin
            state               <= ST_IDLE;
            ptr                 <= '0;
            scan_cnt            <= '0;
            err_spurious        <= 1'b0;
            sched.sel_valid     <= 1'b0;
            sched.sel_id        <= '0;
            sched.sel_head      <= '0;
            sched.sel_tail      <= '0;
            sched.sel_kmem_addr <= '0;
        end else begin
            err_spurious <= sched.dma_done && (state != ST_BUSY);
            case (state)
                ST_IDLE: begin
                    if (sched.req_valid) begin
                        state    <= ST_SEARCH;
                        scan_cnt <= '0;
                    end
                end
                ST_SEARCH: begin
                    if (!sched.req_valid) begin
                        state <= ST_IDLE;
                    end else if (cand_fits) begin
                        state               <= ST_OFFER;
                        sched.sel_valid     <= 1'b1;
                        sched.sel_id        <= cand;
                        sched.sel_head      <= rd_head;
                        sched.sel_tail      <= rd_tail;
                        sched.sel_kmem_addr <= rd_kmem;
                    end else begin
                        ptr      <= cand_next;
                        scan_cnt <= scan_cnt + 5'd1;
                        if (scan_cnt == tc_eff - 5'd1) begin
                            state <= ST_IDLE;
                        end
                    end
                end
                ST_OFFER: begin
                    if (sched.sel_ready) begin
                        state           <= ST_BUSY;
                        sched.sel_valid <= 1'b0;
                    end
                end
                ST_BUSY: begin
                    if (sched.dma_done) begin
                        ptr   <= done_next;
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

`ifdef F2C_SCHED_STATS_EN
    logic grant_ev;
    logic skip_ev;
    logic stall_ev;

    assign grant_ev = (state == ST_OFFER) && sched.sel_ready;
    assign skip_ev  = (state == ST_SEARCH) && sched.req_valid && !cand_fits;
    assign stall_ev = skip_ev && (scan_cnt == tc_eff - 5'd1);

    always_ff @(posedge pcie_clk) begin
        if (!pcie_reset_n) begin
            stat_grants <= '0;
            stat_skips  <= '0;
            stat_stalls <= '0;
        end else begin
            if (grant_ev && (stat_grants != '1)) stat_grants <= stat_grants + 32'd1;
            if (skip_ev && (stat_skips != '1))   stat_skips  <= stat_skips + 32'd1;
            if (stall_ev && (stat_stalls != '1)) stat_stalls <= stat_stalls + 32'd1;
        end
    end
`else
    assign stat_grants = '0;
    assign stat_skips  = '0;
    assign stat_stalls = '0;
`endif

endmodule

// File: tb/tb_f2c_queue_scheduler.sv
// tb/tb_f2c_queue_scheduler.sv - self-checking bench for f2c_queue_scheduler against a transaction-level model
module tb_f2c_queue_scheduler;
    import f2c_queue_scheduler_pkg::*;

    localparam int NQ = MAX_NB_APPS;
    localparam int AW = RB_AWIDTH;

    logic              pcie_clk = 1'b0;
    logic              pcie_reset_n = 1'b0;
    logic [4:0]        total_core = '0;
    logic [25:0]       rb_size = '0;
    logic [NQ*AW-1:0]  heads_flat = '0;
    logic [NQ*64-1:0]  kmem_flat = '0;
    logic [NQ*AW-1:0]  tails_flat;
    logic              err_spurious;
    logic [31:0]       stat_grants, stat_skips, stat_stalls;

    f2c_queue_scheduler_if sif();

    f2c_queue_scheduler #(.NB_QUEUES(NQ)) dut (
        .pcie_clk     (pcie_clk),
        .pcie_reset_n (pcie_reset_n),
        .total_core   (total_core),
        .rb_size      (rb_size),
        .heads_flat   (heads_flat),
        .kmem_flat    (kmem_flat),
        .sched        (sif.master),
        .tails_flat   (tails_flat),
        .err_spurious (err_spurious),
        .stat_grants  (stat_grants),
        .stat_skips   (stat_skips),
        .stat_stalls  (stat_stalls)
    );

    always #5 pcie_clk = ~pcie_clk;

    int errors = 0;
    int checks = 0;

    // reference model state
    int          tail_m [NQ];
    int          head_m [NQ];
    logic [63:0] kmem_m [NQ];
    int          ptr_m, grants_m, skips_m, stalls_m;

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge pcie_clk);
        #1;
    endtask

    function automatic int eff_tc();
        int t;
        t = int'(total_core);
        if (t == 0) return 1;
        if (t > NQ) return NQ;
        return t;
    endfunction

    function automatic int free_m(input int q);
        int rb, used;
        rb = int'(rb_size);
        if (rb == 0) return 0;
        used = ((tail_m[q] - head_m[q]) % rb + rb) % rb;
        return rb - 1 - used;
    endfunction

    function automatic logic [NQ*AW-1:0] tails_exp();
        logic [NQ*AW-1:0] f;
        for (int i = 0; i < NQ; i++) f[i*AW +: AW] = AW'(tail_m[i]);
        return f;
    endfunction

    task automatic set_head(input int i, input int v);
        head_m[i] = v & 16'hffff;
        heads_flat[i*AW +: AW] = AW'(v);
    endtask

    task automatic set_kmem(input int i, input logic [63:0] v);
        kmem_m[i] = v;
        kmem_flat[i*64 +: 64] = v;
    endtask

    task automatic model_reset();
        for (int i = 0; i < NQ; i++) tail_m[i] = 0;
        ptr_m = 0; grants_m = 0; skips_m = 0; stalls_m = 0;
    endtask

    task automatic check_stats(input string tag);
`ifdef F2C_SCHED_STATS_EN
        check({tag, "_grants"}, stat_grants, grants_m);
        check({tag, "_skips"}, stat_skips, skips_m);
        check({tag, "_stalls"}, stat_stalls, stalls_m);
`else
        check({tag, "_grants"}, stat_grants, 0);
        check({tag, "_skips"}, stat_skips, 0);
        check({tag, "_stalls"}, stat_stalls, 0);
`endif
    endtask

    // One engine request: the model predicts the winner (or a full-scan stall), then the bench
    // walks the handshake, optionally holding sel_ready low, injecting a spurious dma_done at
    // accept time, or resetting while BUSY.
    task automatic request(input int sz, input int hold, input int nt, input bit spur,
                           input bit rst_busy, output int got);
        int tc, start, k, q, n;
        logic [100:0] snap;
        tc = eff_tc();
        start = (ptr_m >= tc) ? 0 : ptr_m;
        got = -1;
        k = 0;
        for (int j = 0; j < tc; j++) begin
            q = (start + j) % tc;
            if (got < 0 && sz != 0 && sz <= free_m(q)) begin
                got = q;
                k = j;
            end
        end
        sif.req_valid = 1'b1;
        sif.req_size  = AW'(sz);
        if (got < 0) begin
            for (int j = 0; j <= tc; j++) begin
                tick();
                check("stall_sel_valid", sif.sel_valid, 0);
            end
            sif.req_valid = 1'b0;
            skips_m += tc;
            stalls_m++;
            ptr_m = start;
            return;
        end
        n = 0;
        do begin
            tick();
            n++;
        end while (!sif.sel_valid && n < 40);
        check("latency", n, 2 + k);
        check("sel_id", sif.sel_id, got);
        check("sel_head", sif.sel_head, head_m[got]);
        check("sel_tail", sif.sel_tail, tail_m[got]);
        check("sel_kmem", sif.sel_kmem_addr, kmem_m[got]);
        skips_m += k;
        snap = {sif.sel_valid, sif.sel_id, sif.sel_head, sif.sel_tail, sif.sel_kmem_addr};
        for (int j = 0; j < hold; j++) begin
            tick();
            check("offer_stable", {sif.sel_valid, sif.sel_id, sif.sel_head, sif.sel_tail, sif.sel_kmem_addr}, snap);
        end
        if (hold > 0) check_stats("offer_hold");
        sif.sel_ready = 1'b1;
        sif.dma_done  = spur;
        sif.new_tail  = 16'hbeef;
        tick();
        sif.sel_ready = 1'b0;
        sif.dma_done  = 1'b0;
        sif.req_valid = 1'b0;
        grants_m++;
        check("accept_sel_valid", sif.sel_valid, 0);
        check("accept_err", err_spurious, spur);
        check("accept_tails", tails_flat, tails_exp());
        if (rst_busy) begin
            pcie_reset_n = 1'b0;
            tick();
            pcie_reset_n = 1'b1;
            model_reset();
            check("rst_sel_valid", sif.sel_valid, 0);
            check("rst_sel_id", sif.sel_id, 0);
            check("rst_tails", tails_flat, 0);
            check_stats("rst");
            return;
        end
        repeat ($urandom_range(0, 3)) tick();
        sif.dma_done = 1'b1;
        sif.new_tail = AW'(nt);
        tick();
        sif.dma_done = 1'b0;
        tail_m[got] = nt & 16'hffff;
        ptr_m = (got + 1 == tc) ? 0 : got + 1;
        check("tail_write", tails_flat, tails_exp());
        check("done_err", err_spurious, 0);
    endtask

    initial begin
        int got, rb;
        sif.req_valid = 1'b0;
        sif.req_size  = '0;
        sif.sel_ready = 1'b0;
        sif.dma_done  = 1'b0;
        sif.new_tail  = '0;
        for (int i = 0; i < NQ; i++) begin
            set_head(i, 0);
            set_kmem(i, {$urandom, $urandom});
        end
        model_reset();

        // reset state
        pcie_reset_n = 1'b0;
        tick();
        tick();
        check("reset_sel_valid", sif.sel_valid, 0);
        check("reset_sel_id", sif.sel_id, 0);
        check("reset_sel_kmem", sif.sel_kmem_addr, 0);
        check("reset_tails", tails_flat, 0);
        check("reset_err", err_spurious, 0);
        check_stats("reset");
        pcie_reset_n = 1'b1;
        total_core = 5'd4;
        rb_size = 26'd1024;
        tick();

        // plain rotation over four queues
        for (int i = 0; i < 5; i++) begin
            request(16, 0, tail_m[i % 4] + 16, 1'b0, 1'b0, got);
            check("rotation_grant", got, i % 4);
        end
        check("rotation_tails", tails_flat[63:0], {16'd16, 16'd16, 16'd16, 16'd32});

        // queue 1 nearly full is skipped
        request(16, 0, 1020, 1'b0, 1'b0, got);
        check("fill_q1", got, 1);
        for (int i = 2; i < 5; i++) begin
            request(16, 0, tail_m[i % 4] + 16, 1'b0, 1'b0, got);
            check("refill_grant", got, i % 4);
        end
        request(16, 0, tail_m[2] + 16, 1'b0, 1'b0, got);
        check("skip_grant", got, 2);
`ifdef F2C_SCHED_STATS_EN
        check("skip_count", stat_skips, 1);
`endif
        check_stats("skip");

        // nothing fits: two full-scan stalls, then head[0] catches up
        request(1020, 0, 0, 1'b0, 1'b0, got);
        check("stall1", got, -1);
        request(1020, 0, 0, 1'b0, 1'b0, got);
        check("stall2", got, -1);
`ifdef F2C_SCHED_STATS_EN
        check("stall_count", stat_stalls, 2);
`endif
        check_stats("stall");
        set_head(0, tail_m[0]);
        request(1020, 0, tail_m[0] + 1020, 1'b0, 1'b0, got);
        check("after_head_grant", got, 0);

        // engine back-pressure, then a dma_done coinciding with sel_ready
        request(16, 10, tail_m[ptr_m] + 16, 1'b0, 1'b0, got);
        request(16, 2, 7, 1'b1, 1'b0, got);
        check_stats("backpressure");

        // dma_done while idle
        sif.dma_done = 1'b1;
        sif.new_tail = 16'h1234;
        tick();
        sif.dma_done = 1'b0;
        check("idle_spur_err", err_spurious, 1);
        check("idle_spur_tails", tails_flat, tails_exp());
        tick();
        check("idle_spur_once", err_spurious, 0);

        // reset while BUSY, then a stray completion
        request(16, 0, 0, 1'b0, 1'b1, got);
        sif.dma_done = 1'b1;
        tick();
        sif.dma_done = 1'b0;
        check("post_rst_spur", err_spurious, 1);
        check("post_rst_tails", tails_flat, 0);
        request(16, 0, 16, 1'b0, 1'b0, got);
        check("post_rst_grant", got, 0);

        // randomized traffic with changing queue count, ring size and heads
        for (int t = 0; t < 150; t++) begin
            if ($urandom_range(0, 7) == 0) begin
                total_core = 5'($urandom_range(0, 20));
                rb_size = ($urandom_range(0, 15) == 0) ? 26'd0 : (26'd1 << $urandom_range(2, 10));
            end
            if ($urandom_range(0, 3) == 0) begin
                for (int i = 0; i < NQ; i++) set_head(i, $urandom_range(0, 65535));
            end
            rb = int'(rb_size);
            request($urandom_range(0, rb / 2 + 1), $urandom_range(0, 2), $urandom_range(0, 65535),
                    ($urandom_range(0, 9) == 0), 1'b0, got);
        end
        check_stats("final");
        check("final_tails", tails_flat, tails_exp());

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
